// File: rtl/vram_fill_engine.sv
// Framebuffer fill engine: full-screen clear and (optionally square-brush) pixel plot, one VRAM write per cycle.
// Define VRAM_FILL_BRUSH_EN to enable the (2*BRUSH_R+1)^2 brush; otherwise a plot writes a single pixel.
module vram_fill_engine #(
  parameter int                WIDTH       = 240,
  parameter int                HEIGHT      = 320,
  parameter int                VRAM_W      = 16,
  parameter int                BRUSH_R     = 2,
  parameter logic [VRAM_W-1:0] RESET_COLOR = 16'h0000,
  localparam int               L           = WIDTH * HEIGHT,
  localparam int               AW          = $clog2(L),
  localparam int               XW          = $clog2(WIDTH),
  localparam int               YW          = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  input  logic [VRAM_W-1:0] clear_color,
  input  logic              plot_valid,
  output logic              plot_ready,
  input  logic [XW-1:0]     plot_x,
  input  logic [YW-1:0]     plot_y,
  input  logic [VRAM_W-1:0] plot_color,
  output logic              busy,
  output logic              done,
  output logic              vram_wr_ena,
  output logic [AW-1:0]     vram_wr_addr,
  output logic [VRAM_W-1:0] vram_wr_data
);

`ifdef VRAM_FILL_BRUSH_EN
  localparam int R = BRUSH_R;
`else
  localparam int R = 0;
`endif
  localparam int RW = $clog2(BRUSH_R + 1) + 1;
  localparam int PW = ((XW > YW) ? XW : YW) + RW + 1;
  localparam logic signed [RW-1:0] R_POS = RW'(R);
  localparam logic signed [RW-1:0] R_NEG = RW'(-R);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_PLOT} state_t;

  state_t              r_state;
  logic                r_pend;
  logic [VRAM_W-1:0]   r_pend_color;
  logic [VRAM_W-1:0]   r_color;
  logic [XW-1:0]       r_px;
  logic [YW-1:0]       r_py;
  logic signed [RW-1:0] r_dx;
  logic signed [RW-1:0] r_dy;
  logic                r_wr_ena;
  logic [AW-1:0]       r_wr_addr;
  logic [VRAM_W-1:0]   r_wr_data;
  logic                r_done;

  logic                 w_last;
  logic signed [RW-1:0] w_dx_next;
  logic signed [RW-1:0] w_dy_next;
  logic [XW-1:0]        w_bx;
  logic [YW-1:0]        w_by;
  logic signed [RW-1:0] w_tdx;
  logic signed [RW-1:0] w_tdy;
  logic signed [PW-1:0] w_sx;
  logic signed [PW-1:0] w_sy;
  logic                 w_tap_ena;
  logic [AW-1:0]        w_tap_addr;

  // r_dx/r_dy hold the brush offset already issued; the tap is the one issued next.
  always_comb begin
    w_last    = (r_dx == R_POS) && (r_dy == R_POS);
    w_dx_next = r_dx + RW'(1);
    w_dy_next = r_dy;
    if (r_dx == R_POS) begin
      w_dx_next = R_NEG;
      w_dy_next = r_dy + RW'(1);
    end
    if (r_state == S_IDLE) begin
      w_bx  = plot_x;
      w_by  = plot_y;
      w_tdx = R_NEG;
      w_tdy = R_NEG;
    end else begin
      w_bx  = r_px;
      w_by  = r_py;
      w_tdx = w_dx_next;
      w_tdy = w_dy_next;
    end
    w_sx       = $signed({{(PW-XW){1'b0}}, w_bx}) + PW'(w_tdx);
    w_sy       = $signed({{(PW-YW){1'b0}}, w_by}) + PW'(w_tdy);
    w_tap_ena  = !w_sx[PW-1] && (w_sx < PW'(WIDTH)) && !w_sy[PW-1] && (w_sy < PW'(HEIGHT));
    w_tap_addr = AW'(w_sy) * AW'(WIDTH) + AW'(w_sx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_CLEAR;
      r_color      <= RESET_COLOR;
      r_pend       <= 1'b0;
      r_pend_color <= '0;
      r_px         <= '0;
      r_py         <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_wr_ena     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wr_ena <= 1'b0;
          if (r_pend) begin
            r_pend    <= 1'b0;
            r_state   <= S_CLEAR;
            r_color   <= r_pend_color;
            r_wr_ena  <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= r_pend_color;
          end else if (plot_valid) begin
            r_state   <= S_PLOT;
            r_px      <= plot_x;
            r_py      <= plot_y;
            r_color   <= plot_color;
            r_dx      <= R_NEG;
            r_dy      <= R_NEG;
            r_wr_ena  <= w_tap_ena;
            r_wr_addr <= w_tap_addr;
            r_wr_data <= plot_color;
          end
        end
        S_CLEAR: begin
          // r_wr_ena low here only right after reset: the sweep has not started yet.
          if (r_wr_ena && (r_wr_addr == AW'(L - 1))) begin
            r_state  <= S_IDLE;
            r_wr_ena <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_wr_ena  <= 1'b1;
            r_wr_addr <= r_wr_ena ? r_wr_addr + AW'(1) : '0;
            r_wr_data <= r_color;
          end
        end
        S_PLOT: begin
          if (w_last) begin
            r_state  <= S_IDLE;
            r_wr_ena <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_dx      <= w_dx_next;
            r_dy      <= w_dy_next;
            r_wr_ena  <= w_tap_ena;
            r_wr_addr <= w_tap_addr;
            r_wr_data <= r_color;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_wr_ena <= 1'b0;
        end
      endcase
      // A new request always lands in the pending slot, even on the cycle one is consumed.
      if (clear_req) begin
        r_pend       <= 1'b1;
        r_pend_color <= clear_color;
      end
    end
  end

  assign plot_ready   = (r_state == S_IDLE) && !r_pend;
  assign busy         = (r_state != S_IDLE) || r_pend;
  assign done         = r_done;
  assign vram_wr_ena  = r_wr_ena;
  assign vram_wr_addr = r_wr_addr;
  assign vram_wr_data = r_wr_data;

endmodule
